// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors and the width helper used to
// size pointers and the occupancy counter.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Ceiling log2, never below 1 so a 2-entry FIFO still gets a 1-bit pointer.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: one synchronous write port and one
// asynchronous (combinational) read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset branch; resetting an array forces it into flops
  // and stale contents are harmless because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/synch_fifo_flags.sv
// Single-clock FIFO with registered occupancy flags, overflow/underflow
// pulses, and a choice of registered-read or first-word-fall-through output.
module synch_fifo_flags
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = FIFO_MODE_STD
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [FIFO_WIDTH-1:0]        write_data,
  input  logic                         rd_en,
  output logic [FIFO_WIDTH-1:0]        read_data,
  output logic                         rd_valid,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [clog2(FIFO_DEPTH):0]   data_count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_next;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [FIFO_WIDTH-1:0] ram_rdata;

  // Acceptance looks only at the registered flags, so a same-cycle pop never
  // frees room for a write into a full FIFO (and vice versa when empty).
  assign wr_accept = wr_en && !fifo_full;
  assign rd_accept = rd_en && !fifo_empty;

  fifo_ram #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept && !rst),
    .wr_addr (wr_ptr),
    .wr_data (write_data),
    .rd_addr (rd_ptr),
    .rd_data (ram_rdata)
  );

  // NOTE: every output of this block gets a default first, so no path leaves
  // count_next unassigned and no latch is inferred.
  always_comb begin
    count_next = data_count;
    unique case ({wr_accept, rd_accept})
      2'b10:   count_next = data_count + 1'b1;
      2'b01:   count_next = data_count - 1'b1;
      default: count_next = data_count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      data_count   <= count_next;
      // Flags derive from the next count so they line up with data_count.
      fifo_full    <= (count_next == CW'(FIFO_DEPTH));
      fifo_empty   <= (count_next == '0);
      almost_full  <= (count_next >= CW'(AF_LEVEL));
      almost_empty <= (count_next <= CW'(AE_LEVEL));
      overflow     <= wr_en && fifo_full;
      underflow    <= rd_en && fifo_empty;
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign read_data = ram_rdata;
      assign rd_valid  = !fifo_empty;
    end else begin : g_std
      logic [FIFO_WIDTH-1:0] read_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          read_data_q <= '0;
          rd_valid_q  <= 1'b0;
        end else begin
          rd_valid_q <= rd_accept;
          if (rd_accept) read_data_q <= ram_rdata;
        end
      end

      assign read_data = read_data_q;
      assign rd_valid  = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_synch_fifo_flags.sv
// Directed bench for synch_fifo_flags: one registered-read instance and one
// first-word-fall-through instance, depth 16, width 8.
module tb_synch_fifo_flags;

  logic       clk;
  logic       rst;

  logic       wr_en, rd_en;
  logic [7:0] write_data, read_data;
  logic       rd_valid, fifo_full, fifo_empty, almost_full, almost_empty;
  logic [4:0] data_count;
  logic       overflow, underflow;

  logic       f_wr_en, f_rd_en;
  logic [7:0] f_write_data, f_read_data;
  logic       f_rd_valid, f_full, f_empty, f_af, f_ae;
  logic [4:0] f_count;
  logic       f_overflow, f_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q[$];
  logic [7:0] exp_data;

  synch_fifo_flags #(.FIFO_WIDTH(8), .FIFO_DEPTH(16), .FWFT(0)) u_std (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .write_data   (write_data),
    .rd_en        (rd_en),
    .read_data    (read_data),
    .rd_valid     (rd_valid),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_count   (data_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  synch_fifo_flags #(.FIFO_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1)) u_fwft (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (f_wr_en),
    .write_data   (f_write_data),
    .rd_en        (f_rd_en),
    .read_data    (f_read_data),
    .rd_valid     (f_rd_valid),
    .fifo_full    (f_full),
    .fifo_empty   (f_empty),
    .almost_full  (f_af),
    .almost_empty (f_ae),
    .data_count   (f_count),
    .overflow     (f_overflow),
    .underflow    (f_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs set before the call are sampled on the edge and
  // outputs are observed 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; write_data = '0;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_write_data = '0;
    step();
    step();
    rst = 1'b0;

    check("rst_count", data_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_af", almost_full, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    check("rst_rdata", read_data, 0);

    // Fill with A0..AF.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      write_data = 8'(8'hA0 + i);
      step();
      check("fill_count", data_count, i + 1);
      check("fill_af", almost_full, (i + 1 >= 14));
      check("fill_ae", almost_empty, (i + 1 <= 2));
      check("fill_full", fifo_full, (i + 1 == 16));
      check("fill_empty", fifo_empty, 0);
    end

    write_data = 8'hB0;
    step();
    check("ovf_pulse", overflow, 1);
    check("ovf_count", data_count, 16);
    wr_en = 1'b0;
    step();
    check("ovf_clear", overflow, 0);
    check("ovf_count2", data_count, 16);

    // Drain in order.
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      step();
      check("drain_valid", rd_valid, 1);
      check("drain_data", read_data, 8'hA0 + i);
      check("drain_count", data_count, 15 - i);
    end
    check("drain_empty", fifo_empty, 1);
    step();
    check("unf_pulse", underflow, 1);
    check("unf_valid", rd_valid, 0);
    check("unf_hold", read_data, 8'hAF);
    rd_en = 1'b0;
    step();
    check("unf_clear", underflow, 0);

    // Five words resident, then 20 cycles of simultaneous write/read.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      write_data = 8'(8'h10 + i);
      q.push_back(write_data);
      step();
    end
    check("five_count", data_count, 5);
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      write_data = 8'(8'h20 + i);
      step();
      exp_data = q.pop_front();
      q.push_back(write_data);
      check("stream_data", read_data, exp_data);
      check("stream_valid", rd_valid, 1);
      check("stream_count", data_count, 5);
    end

    // Fill to full, then simultaneous write/read on a full FIFO.
    rd_en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      write_data = 8'(8'h40 + i);
      q.push_back(write_data);
      step();
    end
    check("refill_full", fifo_full, 1);
    check("refill_count", data_count, 16);
    rd_en = 1'b1;
    write_data = 8'h77;
    step();
    exp_data = q.pop_front();
    check("fullrw_ovf", overflow, 1);
    check("fullrw_valid", rd_valid, 1);
    check("fullrw_data", read_data, exp_data);
    check("fullrw_count", data_count, 15);
    check("fullrw_full", fifo_full, 0);

    wr_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      exp_data = q.pop_front();
      check("drain2_data", read_data, exp_data);
    end
    check("drain2_empty", fifo_empty, 1);

    // Simultaneous write/read on an empty FIFO.
    wr_en = 1'b1;
    write_data = 8'h55;
    step();
    q.push_back(8'h55);
    check("emptyrw_unf", underflow, 1);
    check("emptyrw_count", data_count, 1);
    check("emptyrw_empty", fifo_empty, 0);
    check("emptyrw_valid", rd_valid, 0);

    // Grow to 8 words, then reset with a write pending on the same edge.
    rd_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      write_data = 8'(8'h60 + i);
      step();
    end
    check("pre_rst_count", data_count, 8);
    rst = 1'b1;
    write_data = 8'hEE;
    step();
    rst = 1'b0;
    wr_en = 1'b0;
    q.delete();
    check("midrst_count", data_count, 0);
    check("midrst_empty", fifo_empty, 1);
    check("midrst_rdata", read_data, 0);
    check("midrst_full", fifo_full, 0);
    rd_en = 1'b1;
    step();
    check("midrst_unf", underflow, 1);
    check("midrst_valid", rd_valid, 0);
    check("midrst_rdata2", read_data, 0);
    rd_en = 1'b0;

    // First-word-fall-through instance.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("fw_rst_empty", f_empty, 1);
    check("fw_rst_valid", f_rd_valid, 0);
    f_wr_en = 1'b1;
    f_write_data = 8'hC0;
    step();
    check("fw_first_data", f_read_data, 8'hC0);
    check("fw_first_valid", f_rd_valid, 1);
    check("fw_first_count", f_count, 1);
    f_write_data = 8'hC1;
    step();
    check("fw_head_hold", f_read_data, 8'hC0);
    check("fw_count2", f_count, 2);
    f_wr_en = 1'b0;
    f_rd_en = 1'b1;
    step();
    check("fw_pop_data", f_read_data, 8'hC1);
    check("fw_pop_count", f_count, 1);
    check("fw_pop_valid", f_rd_valid, 1);
    step();
    check("fw_empty", f_empty, 1);
    check("fw_empty_valid", f_rd_valid, 0);
    step();
    check("fw_unf", f_underflow, 1);
    f_rd_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
